wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of execution-unit requesters (index 0 = multiplier, 1 = divider).
REQ-002 Parameter DATA_W, default 32: result width.
REQ-003 Parameter SQN_W, default 6: sequence-number and tag width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 IN_valid  in  NUM_REQ  per-requester result valid.
REQ-007 IN_result / IN_tag / IN_nmDst / IN_sqN  in  NUM_REQ x (DATA_W / SQN_W / 5 / SQN_W)  per-requester result, physical tag, architectural destination, sequence number.
REQ-008 OUT_stall  out  NUM_REQ  per-requester stall; requester holds its output while asserted.
REQ-009 IN_wbBlock  in  1  writeback port taken by a higher-priority unit this cycle.
REQ-010 IN_branchTaken  in  1  mispredict flush strobe.
REQ-011 IN_branchSqN  in  SQN_W  sequence number of the mispredicted branch.
REQ-012 OUT_valid / OUT_result / OUT_tag / OUT_nmDst / OUT_sqN  out  1 / DATA_W / SQN_W / 5 / SQN_W  registered writeback beat.
REQ-013 OUT_src  out  clog2(NUM_REQ)  index of the requester that produced the current beat.

Function
REQ-014 The block SHALL hold one result slot (valid bit + fields) per requester.
REQ-015 OUT_stall[i] SHALL be combinational: slot_valid[i] AND NOT grant[i].
REQ-016 Slot i SHALL capture inputs when IN_valid[i] AND NOT OUT_stall[i] AND NOT flushed(IN_sqN[i]); otherwise, if granted, slot i SHALL clear.
REQ-017 flushed(s) SHALL be true iff IN_branchTaken AND signed(s - IN_branchSqN) > 0, computed at SQN_W bits (wrap-around safe); s = IN_branchSqN is never flushed.
REQ-018 Each cycle with IN_branchTaken, every slot with flushed(sqN) SHALL clear and SHALL NOT be granted that cycle.
REQ-019 Grant SHALL be zero when IN_wbBlock = 1; otherwise exactly one valid, non-flushed slot SHALL be granted, when any exists.
REQ-020 Grant selection SHALL be round-robin: search starts at rr_ptr, wraps at NUM_REQ; after a grant to i, rr_ptr SHALL become (i+1) mod NUM_REQ; rr_ptr SHALL be unchanged without a grant.
REQ-021 On grant, OUT_* SHALL load the slot fields next edge with OUT_valid = 1; without a grant, OUT_valid SHALL be 0 next edge and the other OUT fields SHALL hold.
REQ-022 A registered OUT beat SHALL NOT be revoked by a later flush (the consumer filters).
REQ-023 Latency: input accepted at edge t -> OUT_valid at edge t+1 at the earliest (slot captures at t, grant during cycle t+1 drives OUT at edge t+1... i.e. one cycle from slot valid to OUT_valid).
REQ-024 Simultaneous capture and grant on the same slot SHALL keep the slot valid with the new data (back-to-back throughput of 1 per cycle per requester).
REQ-025 Capture during IN_wbBlock SHALL proceed if the slot is empty; a full slot SHALL stall.

Reset
REQ-026 On rst: all slot_valid = 0, rr_ptr = 0, OUT_valid = 0, OUT_result/OUT_tag/OUT_nmDst/OUT_sqN/OUT_src = 0.
REQ-027 rst SHALL override capture, grant and flush in the same cycle; OUT_stall SHALL be 0 during rst and the cycle after.

Configuration
REQ-028 Macro WB_ARB_FIXED_PRIO_EN defined: grant SHALL go to the lowest valid index; rr_ptr SHALL NOT exist.
REQ-029 Macro undefined: round-robin per REQ-020.

Verification
REQ-030 Single: IN_valid[0]=1, result 0x0000_0006, sqN 3 -> next cycle OUT_valid=1, OUT_result=6, OUT_src=0, OUT_stall=0 throughout.
REQ-031 Contention: both slots valid, rr_ptr=0 -> beats src 0 then 1 on consecutive cycles; OUT_stall[1]=1 for exactly one cycle.
REQ-032 Block: slot 0 valid, IN_wbBlock=1 for 3 cycles -> OUT_valid=0, OUT_stall[0]=1 for 3 cycles, beat appears the cycle after release.
REQ-033 Flush wrap: slots sqN 62 and 1, branchSqN 63 -> slot sqN 1 cleared, sqN 62 written back; branchSqN = slot sqN -> kept.
REQ-034 Reset mid-operation: both slots valid, rst pulse -> OUT_valid=0 next cycle, no beat emitted for pre-reset contents.
REQ-035 Streaming: IN_valid[0]=1 every cycle for 8 cycles, no contention -> 8 consecutive OUT beats, OUT_stall[0] never asserted.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the execution units (0 = multiplier, 1 = divider).
// Each requester has one result slot. Every cycle, unless the writeback port is blocked,
// one valid slot that is not being flushed is granted. That slot drives the registered
// OUT_* beat on the next edge.
//
// Configuration:
//   WB_ARB_FIXED_PRIO_EN  defined   -> the lowest valid index wins, and no rotating pointer exists
//                         undefined -> round-robin, starting at rr_ptr_q
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   IN_valid/result/tag/nmDst/sqN   per-requester result offer
//   OUT_stall                per-requester stall (combinational); requester holds its offer
//   IN_wbBlock               writeback port taken by a higher-priority unit this cycle
//   IN_branchTaken/branchSqN mispredict flush; younger sequence numbers are discarded
//   OUT_valid/result/tag/nmDst/sqN/src   registered writeback beat and its source index

module wb_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SQN_W   = 6,
    localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             IN_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] IN_result,
    input  logic [NUM_REQ-1:0][SQN_W-1:0]  IN_tag,
    input  logic [NUM_REQ-1:0][4:0]        IN_nmDst,
    input  logic [NUM_REQ-1:0][SQN_W-1:0]  IN_sqN,
    output logic [NUM_REQ-1:0]             OUT_stall,
    input  logic                           IN_wbBlock,
    input  logic                           IN_branchTaken,
    input  logic [SQN_W-1:0]               IN_branchSqN,
    output logic                           OUT_valid,
    output logic [DATA_W-1:0]              OUT_result,
    output logic [SQN_W-1:0]               OUT_tag,
    output logic [4:0]                     OUT_nmDst,
    output logic [SQN_W-1:0]               OUT_sqN,
    output logic [SRC_W-1:0]               OUT_src
);

    // True when s is younger than the mispredicted branch. The modular difference is
    // read as signed, so the test stays correct when sequence numbers wrap.
    function automatic logic is_flushed(input logic [SQN_W-1:0] s,
                                        input logic             taken,
                                        input logic [SQN_W-1:0] branch_sqn);
        logic [SQN_W-1:0] diff;
        diff = s - branch_sqn;
        return taken && !diff[SQN_W-1] && (diff != '0);
    endfunction

    logic [NUM_REQ-1:0]             slot_valid_q;
    logic [NUM_REQ-1:0][DATA_W-1:0] slot_result_q;
    logic [NUM_REQ-1:0][SQN_W-1:0]  slot_tag_q;
    logic [NUM_REQ-1:0][4:0]        slot_nm_dst_q;
    logic [NUM_REQ-1:0][SQN_W-1:0]  slot_sqn_q;
`ifndef WB_ARB_FIXED_PRIO_EN
    logic [SRC_W-1:0]               rr_ptr_q;
`endif

    logic [NUM_REQ-1:0] slot_flush;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] in_flush;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] capture;
    logic               grant_any;
    logic [SRC_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  sel_result;
    logic [SQN_W-1:0]   sel_tag;
    logic [4:0]         sel_nm_dst;
    logic [SQN_W-1:0]   sel_sqn;

    always_comb begin
        slot_flush = '0;
        eligible   = '0;
        in_flush   = '0;
        grant      = '0;
        capture    = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        sel_result = '0;
        sel_tag    = '0;
        sel_nm_dst = '0;
        sel_sqn    = '0;
        OUT_stall  = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            slot_flush[i] = slot_valid_q[i] &&
                            is_flushed(slot_sqn_q[i], IN_branchTaken, IN_branchSqN);
            eligible[i]   = slot_valid_q[i] && !slot_flush[i];
            in_flush[i]   = is_flushed(IN_sqN[i], IN_branchTaken, IN_branchSqN);
        end

        if (!IN_wbBlock) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && eligible[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SRC_W'(i);
                end
            end
`else
            // First pass covers rr_ptr..NUM_REQ-1, and the second pass wraps to 0..rr_ptr-1.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && eligible[i] && (i >= int'(rr_ptr_q))) begin
                    grant_any = 1'b1;
                    grant_idx = SRC_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && eligible[i] && (i < int'(rr_ptr_q))) begin
                    grant_any = 1'b1;
                    grant_idx = SRC_W'(i);
                end
            end
`endif
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_any && (grant_idx == SRC_W'(i));
            if (grant[i]) begin
                sel_result = slot_result_q[i];
                sel_tag    = slot_tag_q[i];
                sel_nm_dst = slot_nm_dst_q[i];
                sel_sqn    = slot_sqn_q[i];
            end
            OUT_stall[i] = !rst && slot_valid_q[i] && !grant[i];
            capture[i]   = IN_valid[i] && !OUT_stall[i] && !in_flush[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
            OUT_valid    <= 1'b0;
            OUT_result   <= '0;
            OUT_tag      <= '0;
            OUT_nmDst    <= '0;
            OUT_sqN      <= '0;
            OUT_src      <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                // Capturing wins over clearing, so a granted slot refills in the same cycle.
                if (capture[i]) begin
                    slot_valid_q[i]  <= 1'b1;
                    slot_result_q[i] <= IN_result[i];
                    slot_tag_q[i]    <= IN_tag[i];
                    slot_nm_dst_q[i] <= IN_nmDst[i];
                    slot_sqn_q[i]    <= IN_sqN[i];
                end else if (grant[i] || slot_flush[i]) begin
                    slot_valid_q[i]  <= 1'b0;
                end
            end

            OUT_valid <= grant_any;
            if (grant_any) begin
                OUT_result <= sel_result;
                OUT_tag    <= sel_tag;
                OUT_nmDst  <= sel_nm_dst;
                OUT_sqN    <= sel_sqn;
                OUT_src    <= grant_idx;
`ifndef WB_ARB_FIXED_PRIO_EN
                if (grant_idx == SRC_W'(NUM_REQ - 1)) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= grant_idx + 1'b1;
                end
`endif
            end
        end
    end

endmodule
